// File: rtl/i2c_slv_ctrl.sv
// I2C target byte engine: input filtering, START/STOP detection, 7-bit address match,
// ACK/NACK handshakes, RX FIFO pushes and TX FIFO reads with clock stretching.
module i2c_slv_ctrl #(
  parameter int FILT_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cr_en,
  input  logic [6:0] slv_addr,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       tx_fifo_empty,
  input  logic [7:0] tx_fifo_dout,
  output logic       tx_fifo_rd,
  input  logic       rx_fifo_full,
  output logic       rx_fifo_wr,
  output logic [7:0] rx_fifo_din,
  output logic       addressed,
  output logic       srw,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_det
);

  localparam logic [3:0] FILT_M1 = 4'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  logic [1:0] scl_s_q, sda_s_q;
  logic [3:0] scl_cnt_q, sda_cnt_q;
  logic       scl_f_q, sda_f_q, scl_fd_q, sda_fd_q;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] sr_q;
  logic       phase_q, ack_ok_q, stretch_q, scl_rel_q;
  logic       scl_oe_q, sda_oe_q, tx_rd_q, rx_wr_q, addr_q, srw_q;
  logic       start_q, stop_q, nack_q;
  logic [7:0] rx_din_q;

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c, load_c;

  // A filtered level flips only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s_q   <= 2'b11;
      sda_s_q   <= 2'b11;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_fd_q  <= 1'b1;
      sda_fd_q  <= 1'b1;
    end else begin
      scl_s_q  <= {scl_s_q[0], scl_i};
      sda_s_q  <= {sda_s_q[0], sda_i};
      scl_fd_q <= scl_f_q;
      sda_fd_q <= sda_f_q;
      if (scl_s_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FILT_M1) begin
        scl_f_q   <= scl_s_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 4'd1;
      end
      if (sda_s_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FILT_M1) begin
        sda_f_q   <= sda_s_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 4'd1;
      end
    end
  end

  assign scl_rise = scl_f_q & ~scl_fd_q;
  assign scl_fall = ~scl_f_q & scl_fd_q;
  assign sda_rise = sda_f_q & ~sda_fd_q;
  assign sda_fall = ~sda_f_q & sda_fd_q;
  assign start_c  = sda_fall & scl_f_q;
  assign stop_c   = sda_rise & scl_f_q;
  // Byte load point: the SCL fall that closes the address ACK of a read or a master ACK
  assign load_c   = scl_fall & phase_q &
                    (((state_q == S_ADDR_ACK) & srw_q) | (state_q == S_TX_ACK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      phase_q   <= 1'b0;
      ack_ok_q  <= 1'b0;
      stretch_q <= 1'b0;
      scl_rel_q <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      tx_rd_q   <= 1'b0;
      rx_wr_q   <= 1'b0;
      rx_din_q  <= '0;
      addr_q    <= 1'b0;
      srw_q     <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      nack_q  <= 1'b0;
      tx_rd_q <= 1'b0;
      rx_wr_q <= 1'b0;
      if (!cr_en || stop_c) begin
        state_q   <= S_IDLE;
        stop_q    <= cr_en;
        addr_q    <= 1'b0;
        sda_oe_q  <= 1'b0;
        scl_oe_q  <= 1'b0;
        stretch_q <= 1'b0;
        scl_rel_q <= 1'b0;
      end else if (start_c) begin
        state_q   <= S_ADDR;
        start_q   <= 1'b1;
        addr_q    <= 1'b0;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        scl_oe_q  <= 1'b0;
        stretch_q <= 1'b0;
        scl_rel_q <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: if (scl_rise) begin
            sr_q      <= {sr_q[5:0], sda_f_q};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (sr_q == slv_addr) begin
                srw_q   <= sda_f_q;
                phase_q <= 1'b0;
                state_q <= S_ADDR_ACK;
              end else begin
                state_q <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_q <= 1'b1;
              addr_q   <= 1'b1;
              phase_q  <= 1'b1;
            end else if (!srw_q) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= S_RX;
            end
          end
          S_RX: if (scl_rise) begin
            sr_q      <= {sr_q[5:0], sda_f_q};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q  <= S_RX_ACK;
              phase_q  <= 1'b0;
              ack_ok_q <= ~rx_fifo_full;
              if (!rx_fifo_full) begin
                rx_wr_q  <= 1'b1;
                rx_din_q <= {sr_q, sda_f_q};
              end
            end
          end
          S_RX_ACK: if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_q <= ack_ok_q;
              phase_q  <= 1'b1;
            end else begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= S_RX;
            end
          end
          S_TX: if (stretch_q) begin
            // SCL is held one extra cycle so the MSB settles before the master resumes
            if (scl_rel_q) begin
              scl_oe_q  <= 1'b0;
              scl_rel_q <= 1'b0;
              stretch_q <= 1'b0;
            end else if (!tx_fifo_empty) begin
              tx_rd_q   <= 1'b1;
              sr_q      <= tx_fifo_dout[6:0];
              sda_oe_q  <= ~tx_fifo_dout[7];
              scl_rel_q <= 1'b1;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_q <= 1'b0;
              phase_q  <= 1'b0;
              state_q  <= S_TX_ACK;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              sr_q      <= {sr_q[5:0], 1'b0};
              sda_oe_q  <= ~sr_q[6];
            end
          end
          S_TX_ACK: if (scl_rise && !phase_q) begin
            if (sda_f_q) begin
              nack_q  <= 1'b1;
              state_q <= S_WAIT_STOP;
            end else begin
              phase_q <= 1'b1;
            end
          end
          default: ;
        endcase
        if (load_c) begin
          state_q   <= S_TX;
          bit_cnt_q <= '0;
          phase_q   <= 1'b0;
          if (!tx_fifo_empty) begin
            tx_rd_q  <= 1'b1;
            sr_q     <= tx_fifo_dout[6:0];
            sda_oe_q <= ~tx_fifo_dout[7];
          end else begin
            sda_oe_q  <= 1'b0;
            scl_oe_q  <= 1'b1;
            stretch_q <= 1'b1;
          end
        end
      end
    end
  end

  assign scl_oe      = scl_oe_q;
  assign sda_oe      = sda_oe_q;
  assign tx_fifo_rd  = tx_rd_q;
  assign rx_fifo_wr  = rx_wr_q;
  assign rx_fifo_din = rx_din_q;
  assign addressed   = addr_q;
  assign srw         = srw_q;
  assign start_det   = start_q;
  assign stop_det    = stop_q;
  assign nack_det    = nack_q;

endmodule

// File: tb/tb_i2c_slv_ctrl.sv
// Bench for i2c_slv_ctrl: bit-banged I2C master on a wired-AND bus, a TX FIFO model,
// and a scoreboard of expected strobes plus queued value checks drained by one monitor.
module tb_i2c_slv_ctrl;

  localparam int Q = 10;
  localparam int EV_START = 1, EV_STOP = 2, EV_NACK = 3, EV_TXRD = 4, EV_RXWR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cr_en;
  logic [6:0] slv_addr;
  logic       m_scl, m_sda, scl_i, sda_i, scl_oe, sda_oe;
  logic       tx_fifo_empty, tx_fifo_rd, rx_fifo_full, rx_fifo_wr;
  logic [7:0] tx_fifo_dout, rx_fifo_din;
  logic       addressed, srw, start_det, stop_det, nack_det;

  assign scl_i = m_scl & ~scl_oe;
  assign sda_i = m_sda & ~sda_oe;

  logic [7:0] txmem [0:15];
  int tx_wp = 0;
  int tx_rp = 0;
  assign tx_fifo_empty = (tx_wp == tx_rp);
  assign tx_fifo_dout  = txmem[tx_rp[3:0]];
  always @(posedge clk) if (tx_fifo_rd && tx_wp != tx_rp) tx_rp <= tx_rp + 1;

  i2c_slv_ctrl #(.FILT_LEN(2)) dut (
    .clk(clk), .rst(rst), .cr_en(cr_en), .slv_addr(slv_addr),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .tx_fifo_empty(tx_fifo_empty), .tx_fifo_dout(tx_fifo_dout), .tx_fifo_rd(tx_fifo_rd),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_wr(rx_fifo_wr), .rx_fifo_din(rx_fifo_din),
    .addressed(addressed), .srw(srw), .start_det(start_det), .stop_det(stop_det),
    .nack_det(nack_det)
  );

  typedef struct { int kind; logic [7:0] data; } ev_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;
  ev_t  exp_q[$];
  chk_t chk_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] dbuf [0:7];
  logic       fbuf [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tx_push(input logic [7:0] d);
    txmem[tx_wp[3:0]] = d;
    tx_wp = tx_wp + 1;
  endtask

  // Monitor: the only process that compares and counts
  always @(negedge clk) begin
    int n, k;
    ev_t e;
    chk_t c;
    if (!rst) begin
      n = int'(start_det) + int'(stop_det) + int'(nack_det) + int'(tx_fifo_rd) + int'(rx_fifo_wr);
      k = start_det ? EV_START : stop_det ? EV_STOP : nack_det ? EV_NACK :
          tx_fifo_rd ? EV_TXRD : EV_RXWR;
      if (n > 1) begin
        vectors++; miscompares++;
        $display("FAIL strobes: %0d strobes in one cycle, required at most 1", n);
      end else if (n == 1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL strobe: got unexpected event %0d, required none", k);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || (k == EV_RXWR && e.data !== rx_fifo_din)) begin
            miscompares++;
            $display("FAIL strobe: got event %0d data %02h, required event %0d data %02h",
                     k, rx_fifo_din, e.kind, e.data);
          end
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      vectors++;
      if (c.act !== c.exp) begin
        miscompares++;
        $display("FAIL %s: got %0h, required %0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic s);
    int t;
    m_sda = b;
    cyc(Q);
    m_scl = 1'b1;
    t = 0;
    while (scl_i !== 1'b1 && t < 4000) begin cyc(1); t++; end
    if (t >= 4000) check("scl_release", 32'(scl_i), 1);
    cyc(Q);
    s = sda_i;
    cyc(Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin bit_x(1'b1, s); d = {d[6:0], s}; end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    m_sda = 1'b1; cyc(2 * Q);
  endtask

  // Transaction-level reference: ACK only on own address, RX push only when not full,
  // reads return the queued TX bytes in order (released bus reads as 0xFF).
  task automatic xfer(input logic [6:0] a, input logic rw, input int n, input bit do_stop);
    logic ack, s;
    logic [7:0] d;
    bit match;
    match = (a == slv_addr);
    expect_ev(EV_START, 8'h00);
    i2c_start();
    if (rw && match) begin
      for (int i = 0; i < n; i++) tx_push(dbuf[i]);
      expect_ev(EV_TXRD, 8'h00);
    end
    send_byte({a, rw}, ack);
    check("addr_ack", 32'(ack), 32'(match));
    check("addressed", 32'(addressed), 32'(match));
    if (match) check("srw", 32'(srw), 32'(rw));
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        rx_fifo_full = fbuf[i];
        if (match && !fbuf[i]) expect_ev(EV_RXWR, dbuf[i]);
        send_byte(dbuf[i], ack);
        check("data_ack", 32'(ack), 32'(match && !fbuf[i]));
        rx_fifo_full = 1'b0;
      end else begin
        read_byte(d);
        check("rd_data", 32'(d), match ? 32'(dbuf[i]) : 32'hFF);
        if (i < n - 1) begin
          if (match) expect_ev(EV_TXRD, 8'h00);
          bit_x(1'b0, s);
        end else begin
          if (match) expect_ev(EV_NACK, 8'h00);
          bit_x(1'b1, s);
        end
      end
    end
    if (do_stop) begin
      expect_ev(EV_STOP, 8'h00);
      i2c_stop();
      check("addressed_after_stop", 32'(addressed), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, s;
    logic [7:0] d;
    logic [3:0] part;
    logic [6:0] a;
    logic rw;
    int n, t;
    rst = 1'b1; cr_en = 1'b0; slv_addr = 7'h50; m_scl = 1'b1; m_sda = 1'b1; rx_fifo_full = 1'b0;
    cyc(3);
    check("reset_outputs", 32'({scl_oe, sda_oe, tx_fifo_rd, rx_fifo_wr, rx_fifo_din, addressed,
                                srw, start_det, stop_det, nack_det}), 0);
    rst = 1'b0; cr_en = 1'b1;
    cyc(5);

    // write two bytes
    dbuf[0] = 8'h12; dbuf[1] = 8'h34; fbuf[0] = 1'b0; fbuf[1] = 1'b0;
    xfer(7'h50, 1'b0, 2, 1'b1);

    // wrong address
    dbuf[0] = 8'h77; fbuf[0] = 1'b0;
    xfer(7'h51, 1'b0, 1, 1'b1);

    // read two bytes, ACK then NACK
    dbuf[0] = 8'hA5; dbuf[1] = 8'h3C;
    xfer(7'h50, 1'b1, 2, 1'b1);

    // read with empty TX FIFO at load point
    expect_ev(EV_START, 8'h00);
    i2c_start();
    expect_ev(EV_TXRD, 8'h00);
    send_byte(8'hA1, ack);
    check("st_addr_ack", 32'(ack), 1);
    cyc(20);
    check("stretch_oe", 32'(scl_oe), 1);
    check("stretch_scl", 32'(scl_i), 0);
    tx_push(8'h81);
    t = 0;
    while (scl_oe && t < 50) begin cyc(1); t++; end
    check("stretch_release", 32'(scl_oe), 0);
    read_byte(d);
    check("st_data", 32'(d), 32'h81);
    expect_ev(EV_NACK, 8'h00);
    bit_x(1'b1, s);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();

    // RX FIFO full on second byte
    dbuf[0] = 8'h5A; dbuf[1] = 8'hC3; fbuf[0] = 1'b0; fbuf[1] = 1'b1;
    xfer(7'h50, 1'b0, 2, 1'b1);

    // randomized transactions
    for (int r = 0; r < 8; r++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        dbuf[i] = 8'($urandom);
        fbuf[i] = ($urandom_range(0, 4) == 0);
      end
      xfer(a, rw, n, 1'b1);
    end

    // repeated START mid-RX into a read, then reset mid-TX
    dbuf[0] = 8'h12; fbuf[0] = 1'b0;
    xfer(7'h50, 1'b0, 1, 1'b0);
    bit_x(1'b1, s); bit_x(1'b0, s); bit_x(1'b1, s);
    tx_push(8'hC3); tx_push(8'h5A);
    expect_ev(EV_START, 8'h00);
    i2c_start();
    check("rs_addressed", 32'(addressed), 0);
    expect_ev(EV_TXRD, 8'h00);
    send_byte(8'hA1, ack);
    check("rs_addr_ack", 32'(ack), 1);
    check("rs_srw", 32'(srw), 1);
    check("rs_addressed_ack", 32'(addressed), 1);
    read_byte(d);
    check("rs_data", 32'(d), 32'hC3);
    expect_ev(EV_TXRD, 8'h00);
    bit_x(1'b0, s);
    part = '0;
    for (int i = 0; i < 4; i++) begin bit_x(1'b1, s); part = {part[2:0], s}; end
    check("rs_partial", 32'(part), 32'h5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_outputs", 32'({scl_oe, sda_oe, tx_fifo_rd, rx_fifo_wr, rx_fifo_din,
                                     addressed, srw, start_det, stop_det, nack_det, sda_i}), 1);
    cyc(3);
    rst = 1'b0;
    cyc(Q);
    expect_ev(EV_STOP, 8'h00);
    i2c_stop();
    dbuf[0] = 8'($urandom); fbuf[0] = 1'b0;
    xfer(7'h50, 1'b0, 1, 1'b1);

    cyc(5);
    check("pending_events", 32'(exp_q.size()), 0);
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
